instr_fetch_unit: RTL and testbench

- Upstream neighbour of the single-cycle control unit and datapath.
- Owns the PC and fetches instructions from instruction memory over a req/ack handshake that tolerates variable latency.
- Presents instr, pc and pcPlus4 with a valid/ready handshake to decode, which supplies the opcode, funct3 and funct7 fields to the control unit.
- Applies the taken-branch redirect (pcSrc = branch & zero, computed downstream) when an instruction retires.

---
 rtl/riscv_pkg.sv | 16 +
 rtl/instr_fetch_unit.sv | 99 +++++++++
 tb/tb_instr_fetch_unit.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the instruction fetch unit and its neighbours.
// Holds datapath width, reset vector, canonical nop and fetch FSM states.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        VALID = 2'd2,
        FAULT = 2'd3
    } ifu_state_t;

endpackage

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches over a req/ack memory handshake
// and hands instructions to decode over valid/ready. Build option: IFU_MISALIGN_CHECK_EN.
//
// state | meaning
// IDLE  | one settling cycle after reset release
// FETCH | request outstanding at pc, waiting for imemAck
// VALID | instr/pc presented to decode, waiting for instrReady
// FAULT | misaligned branch target taken; halted until reset
module instr_fetch_unit
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter logic [XLEN-1:0] RESET_PC = riscv_pkg::DEFAULT_RESET_PC
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imemReq,
    output logic [XLEN-1:0] imemAddr,
    input  logic            imemAck,
    input  logic [31:0]     imemRdata,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pcPlus4,
    output logic            instrValid,
    input  logic            instrReady,
    input  logic            pcSrc,
    input  logic [XLEN-1:0] pcTarget,
    output logic            fetchFault
);

    ifu_state_t      state, state_next;
    logic [XLEN-1:0] pc_next;
    logic [31:0]     instr_next;
    logic            fault_next;
    logic            fault_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc      <= RESET_PC;
            instr   <= NOP_INSTR;
            fault_q <= 1'b0;
        end else begin
            state   <= state_next;
            pc      <= pc_next;
            instr   <= instr_next;
            fault_q <= fault_next;
        end
    end

    always_comb begin
        state_next = state;
        pc_next    = pc;
        instr_next = instr;
        fault_next = fault_q;
        case (state)
            IDLE: state_next = FETCH;
            FETCH: begin
                if (imemAck) begin
                    instr_next = imemRdata;
                    state_next = VALID;
                end
            end
            VALID: begin
                if (instrReady) begin
                    state_next = FETCH;
                    if (pcSrc) begin
`ifdef IFU_MISALIGN_CHECK_EN
                        pc_next = pcTarget;
                        if (pcTarget[1:0] != 2'b00) begin
                            fault_next = 1'b1;
                            state_next = FAULT;
                        end
`else
                        // Low bits dropped so a bad target can never desynchronise fetch.
                        pc_next = pcTarget & ~XLEN'(3);
`endif
                    end else begin
                        pc_next = pc + XLEN'(4);
                    end
                end
            end
            default: state_next = state;
        endcase
    end

    // Request and valid decode straight from state so reset drops them at once.
    assign imemReq    = (state == FETCH);
    assign imemAddr   = pc;
    assign instrValid = (state == VALID);
    assign pcPlus4    = pc + XLEN'(4);

`ifdef IFU_MISALIGN_CHECK_EN
    assign fetchFault = fault_q;
`else
    assign fetchFault = 1'b0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: memory model, scoreboard of fetched
// words, and scenario tasks covering latency, backpressure, redirects and reset.
module tb_instr_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck = 1'b0;
    logic [31:0] imemRdata = 32'h0;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic        instrValid;
    logic        instrReady = 1'b0;
    logic        pcSrc = 1'b0;
    logic [31:0] pcTarget = 32'h0;
    logic        fetchFault;

    int checks = 0;
    int errors = 0;
    exp_t sb[$];

    instr_fetch_unit #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imemReq(imemReq), .imemAddr(imemAddr), .imemAck(imemAck), .imemRdata(imemRdata),
        .instr(instr), .pc(pc), .pcPlus4(pcPlus4), .instrValid(instrValid),
        .instrReady(instrReady), .pcSrc(pcSrc), .pcTarget(pcTarget), .fetchFault(fetchFault)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B9) ^ 32'h00A5_5A01;
    endfunction

    // One full instruction: wait for the request, ack after lat cycles, check the
    // presented instruction, stall for stall cycles, then retire with src/tgt.
    task automatic fetch(input logic [31:0] addr, input int lat, input int stall,
                         input logic src, input logic [31:0] tgt, output int waited);
        exp_t e;
        waited = 0;
        while (imemReq !== 1'b1 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (imemReq !== 1'b1) begin
            errors++;
            $display("FAIL req_timeout: imemReq=%b want 1 for addr %h", imemReq, addr);
        end
        checks++;
        if (imemAddr !== addr) begin
            errors++;
            $display("FAIL fetch_addr: got %h want %h", imemAddr, addr);
        end
        for (int k = 1; k < lat; k++) begin
            imemAck = 1'b0;
            @(negedge clk);
            checks++;
            if (imemReq !== 1'b1 || imemAddr !== addr || instrValid !== 1'b0) begin
                errors++;
                $display("FAIL wait_hold: req=%b addr=%h valid=%b want 1/%h/0",
                         imemReq, imemAddr, instrValid, addr);
            end
        end
        imemAck   = 1'b1;
        imemRdata = mem_word(addr);
        e.pc      = addr;
        e.instr   = mem_word(addr);
        sb.push_back(e);
        @(negedge clk);
        imemAck   = 1'b0;
        imemRdata = 32'hDEAD_BEEF;
        checks++;
        if (instrValid !== 1'b1 || imemReq !== 1'b0) begin
            errors++;
            $display("FAIL valid_after_ack: valid=%b req=%b want 1/0", instrValid, imemReq);
        end
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL scoreboard_empty: got 0 entries want 1");
            e.pc = 32'hx;
            e.instr = 32'hx;
        end else begin
            e = sb.pop_front();
        end
        checks++;
        if (instr !== e.instr || pc !== e.pc || pcPlus4 !== e.pc + 32'd4) begin
            errors++;
            $display("FAIL presented: instr=%h pc=%h pc4=%h want %h/%h/%h",
                     instr, pc, pcPlus4, e.instr, e.pc, e.pc + 32'd4);
        end
        for (int s = 0; s < stall; s++) begin
            instrReady = 1'b0;
            imemAck    = 1'b1;
            @(negedge clk);
            checks++;
            if (instrValid !== 1'b1 || instr !== e.instr || pc !== e.pc || imemReq !== 1'b0) begin
                errors++;
                $display("FAIL backpressure: valid=%b instr=%h pc=%h req=%b want 1/%h/%h/0",
                         instrValid, instr, pc, imemReq, e.instr, e.pc);
            end
        end
        imemAck    = 1'b0;
        instrReady = 1'b1;
        pcSrc      = src;
        pcTarget   = tgt;
        @(negedge clk);
        instrReady = 1'b0;
        pcSrc      = 1'b0;
        pcTarget   = $urandom;
    endtask

    task automatic test_reset();
        rst_n   = 1'b0;
        imemAck = 1'b1;
        #12;
        checks++;
        if (imemReq !== 1'b0 || instrValid !== 1'b0 || fetchFault !== 1'b0 ||
            pc !== RST_PC || instr !== NOP) begin
            errors++;
            $display("FAIL reset_state: req=%b valid=%b fault=%b pc=%h instr=%h want 0/0/0/%h/%h",
                     imemReq, instrValid, fetchFault, pc, instr, RST_PC, NOP);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (imemReq !== 1'b1 || instrValid !== 1'b0 || imemAddr !== RST_PC) begin
            errors++;
            $display("FAIL idle_ack_ignored: req=%b valid=%b addr=%h want 1/0/%h",
                     imemReq, instrValid, imemAddr, RST_PC);
        end
        imemAck = 1'b0;
    endtask

    task automatic test_zero_wait();
        int w;
        for (int i = 0; i < 4; i++) begin
            fetch(32'(i * 4), 1, 0, 1'b0, $urandom, w);
            checks++;
            if (w != 0) begin
                errors++;
                $display("FAIL throughput: request %0d came %0d cycles late, want 0", i, w);
            end
        end
    endtask

    task automatic test_latency();
        int w;
        fetch(32'h10, 3, 0, 1'b0, 32'h0000_0080, w);
    endtask

    task automatic test_backpressure();
        int w;
        fetch(32'h14, 1, 5, 1'b0, $urandom, w);
    endtask

    task automatic test_branch();
        int w;
        fetch(32'h18, 1, 0, 1'b1, 32'h0000_0040, w);
        fetch(32'h40, 2, 0, 1'b1, 32'hFFFF_FFFC, w);
        fetch(32'hFFFF_FFFC, 1, 0, 1'b0, $urandom, w);
    endtask

    task automatic test_misalign();
        int w;
        fetch(32'h0, 1, 0, 1'b1, 32'h0000_0042, w);
`ifdef IFU_MISALIGN_CHECK_EN
        checks++;
        if (fetchFault !== 1'b1 || imemReq !== 1'b0 || instrValid !== 1'b0 || pc !== 32'h42) begin
            errors++;
            $display("FAIL fault_entry: fault=%b req=%b valid=%b pc=%h want 1/0/0/42",
                     fetchFault, imemReq, instrValid, pc);
        end
        for (int i = 0; i < 8; i++) begin
            imemAck = 1'b1;
            @(negedge clk);
            checks++;
            if (fetchFault !== 1'b1 || imemReq !== 1'b0 || instrValid !== 1'b0) begin
                errors++;
                $display("FAIL fault_hold: fault=%b req=%b valid=%b want 1/0/0",
                         fetchFault, imemReq, instrValid);
            end
        end
        imemAck = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (fetchFault !== 1'b0 || pc !== RST_PC) begin
            errors++;
            $display("FAIL fault_reset: fault=%b pc=%h want 0/%h", fetchFault, pc, RST_PC);
        end
        @(negedge clk);
        rst_n = 1'b1;
        fetch(RST_PC, 1, 0, 1'b0, $urandom, w);
`else
        checks++;
        if (fetchFault !== 1'b0) begin
            errors++;
            $display("FAIL fault_tied: fault=%b want 0", fetchFault);
        end
        fetch(32'h40, 1, 0, 1'b0, $urandom, w);
`endif
    endtask

    task automatic test_async_reset();
        int w;
        w = 0;
        while (imemReq !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        imemAck = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (imemReq !== 1'b0 || instrValid !== 1'b0 || pc !== RST_PC) begin
            errors++;
            $display("FAIL async_reset: req=%b valid=%b pc=%h want 0/0/%h",
                     imemReq, instrValid, pc, RST_PC);
        end
        imemAck   = 1'b1;
        imemRdata = 32'hBAD0_0BAD;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        imemAck = 1'b0;
        checks++;
        if (imemReq !== 1'b1 || imemAddr !== RST_PC || instrValid !== 1'b0 || instr !== NOP) begin
            errors++;
            $display("FAIL stale_ack: req=%b addr=%h valid=%b instr=%h want 1/%h/0/%h",
                     imemReq, imemAddr, instrValid, instr, RST_PC, NOP);
        end
        fetch(RST_PC, 1, 0, 1'b0, $urandom, w);
        fetch(RST_PC + 32'd4, 1, 0, 1'b0, $urandom, w);
    endtask

    initial begin
        test_reset();
        test_zero_wait();
        test_latency();
        test_backpressure();
        test_branch();
        test_misalign();
        test_async_reset();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover: got %0d entries want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
